// File: rtl/dog_gfx_pkg.sv
// dog_gfx_pkg: shared palette, colour constants, power-state encodings and pipeline types
package dog_gfx_pkg;
  typedef logic [5:0] rgb_t;
  typedef enum logic [1:0] {PWR_NORMAL, PWR_BRIGHT, PWR_INV, PWR_BLINK} pwr_e;
  localparam rgb_t BG_RGB = 6'b000001;
  localparam rgb_t WHITE_RGB = 6'b111111;
  localparam rgb_t PALETTE [8] = '{
    6'b000000, 6'b100100, 6'b111010, 6'b110000,
    6'b001100, 6'b000011, 6'b111100, 6'b111111
  };
  typedef struct packed {
    logic [9:0] sx;
    logic [8:0] sy;
    logic [2:0] scol;
    pwr_e spow;
    logic [7:0] hits_prev;
    logic [3:0] flash_cnt;
    logic [3:0] frame_ctr;
  } shadow_t;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic in_box;
    logic on_edge;
    logic flash;
    logic blink;
    logic [2:0] col;
    logic [1:0] pow;
  } pix1_t;
  function automatic rgb_t pwr_apply(rgb_t base, logic [1:0] pow, logic blink);
    return pow == PWR_BRIGHT ? base | 6'b010101 :
           pow == PWR_INV ? ~base :
           (pow == PWR_BLINK && blink) ? BG_RGB : base;
  endfunction
endpackage

// File: rtl/dog_sprite_render_if.sv
// dog_sprite_render_if: beam, game-state and pixel-output signals of the sprite renderer
interface dog_sprite_render_if;
  logic frame_tick, de, hsync_in, vsync_in;
  logic [9:0] hpos, vpos, posx;
  logic [8:0] posy;
  logic [2:0] color_idx;
  logic [7:0] hits;
  logic [1:0] power_state, r, g, b;
  logic hsync_out, vsync_out, in_sprite;
  modport master (
    output frame_tick, de, hsync_in, vsync_in, hpos, vpos, posx, posy, color_idx, hits, power_state,
    input r, g, b, hsync_out, vsync_out, in_sprite
  );
  modport slave (
    input frame_tick, de, hsync_in, vsync_in, hpos, vpos, posx, posy, color_idx, hits, power_state,
    output r, g, b, hsync_out, vsync_out, in_sprite
  );
endinterface

// File: rtl/dog_frame_latch.sv
// dog_frame_latch: per-frame shadow of dog state, hit-flash countdown and frame counter
module dog_frame_latch
  import dog_gfx_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic [9:0] posx_i,
  input  logic [8:0] posy_i,
  input  logic [2:0] color_idx_i,
  input  logic [7:0] hits_i,
  input  logic [1:0] power_state_i,
  output logic [9:0] sx_o,
  output logic [8:0] sy_o,
  output logic [2:0] scol_o,
  output pwr_e       spow_o,
  output logic       flash_o,
  output logic       blink_o
);
  shadow_t st_q, st_d;
  always_comb begin
    st_d = st_q;
    if (frame_tick_i) begin
      st_d.sx = posx_i;
      st_d.sy = posy_i;
      st_d.scol = color_idx_i;
      st_d.spow = pwr_e'(power_state_i);
      st_d.frame_ctr = st_q.frame_ctr + 4'd1;
      st_d.flash_cnt = hits_i != st_q.hits_prev ? 4'(FLASH_FRAMES)
                                                : st_q.flash_cnt - {3'b0, |st_q.flash_cnt};
      st_d.hits_prev = hits_i;
    end
  end
  always_ff @(posedge clk) st_q <= rst ? '0 : st_d;
  assign sx_o = st_q.sx;
  assign sy_o = st_q.sy;
  assign scol_o = st_q.scol;
  assign spow_o = st_q.spow;
  assign flash_o = |st_q.flash_cnt && st_q.frame_ctr[1];
  assign blink_o = st_q.frame_ctr[2];
endmodule

// File: rtl/dog_sprite_render.sv
// dog_sprite_render: 2-cycle pixel pipeline drawing dog 0's box with hit-flash and power effects
module dog_sprite_render
  import dog_gfx_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BOX_W        = 48,
  parameter int BOX_H        = 32,
  parameter int FLASH_FRAMES = 8
) (
  input logic clk,
  input logic rst,
  dog_sprite_render_if.slave bus
);
  if (BOX_W > SCREEN_W || BOX_H > SCREEN_H) begin : g_bad_box
    $error("sprite box larger than screen");
  end
  localparam pix1_t S1_RST = '{hs: 1'b1, vs: 1'b1, default: '0};
  logic [9:0] sx;
  logic [8:0] sy;
  logic [2:0] scol;
  pwr_e spow;
  logic flash, blink;
  dog_frame_latch #(.FLASH_FRAMES(FLASH_FRAMES)) u_latch (
    .clk(clk), .rst(rst), .frame_tick_i(bus.frame_tick),
    .posx_i(bus.posx), .posy_i(bus.posy), .color_idx_i(bus.color_idx),
    .hits_i(bus.hits), .power_state_i(bus.power_state),
    .sx_o(sx), .sy_o(sy), .scol_o(scol), .spow_o(spow), .flash_o(flash), .blink_o(blink)
  );
  // 11-bit compares so a box near x=1023 never wraps back onto column 0
  logic [10:0] hx, vy, sx_w, sy_w;
  logic inx, iny;
  pix1_t s1_q, s1_d;
  rgb_t rgb_q, rgb_d;
  logic ins_q, hs_q, vs_q;
  assign hx = {1'b0, bus.hpos};
  assign vy = {1'b0, bus.vpos};
  assign sx_w = {1'b0, sx};
  assign sy_w = {2'b0, sy};
  assign inx = hx >= sx_w && hx < sx_w + 11'(BOX_W);
  assign iny = vy >= sy_w && vy < sy_w + 11'(BOX_H);
  // colour-effect state travels with the pixel so a frame_tick mid-pipeline cannot tear it
  always_comb begin
    s1_d = '{de: bus.de, hs: bus.hsync_in, vs: bus.vsync_in, in_box: inx && iny,
             on_edge: inx && iny && (hx == sx_w || hx == sx_w + 11'(BOX_W - 1) ||
                                     vy == sy_w || vy == sy_w + 11'(BOX_H - 1)),
             flash: flash, blink: blink, col: scol, pow: spow};
    rgb_d = !s1_q.de ? '0 :
            !s1_q.in_box ? BG_RGB :
            (s1_q.flash || s1_q.on_edge) ? WHITE_RGB :
            pwr_apply(PALETTE[s1_q.col], s1_q.pow, s1_q.blink);
  end
  always_ff @(posedge clk) begin
    s1_q <= rst ? S1_RST : s1_d;
    rgb_q <= rst ? '0 : rgb_d;
    ins_q <= !rst && s1_q.de && s1_q.in_box;
    hs_q <= rst || s1_q.hs;
    vs_q <= rst || s1_q.vs;
  end
  assign bus.r = rgb_q[5:4];
  assign bus.g = rgb_q[3:2];
  assign bus.b = rgb_q[1:0];
  assign bus.in_sprite = ins_q;
  assign bus.hsync_out = hs_q;
  assign bus.vsync_out = vs_q;
endmodule

// File: tb/tb_dog_sprite_render.sv
// tb_dog_sprite_render: directed pixels with a due-cycle scoreboard checked by a separate monitor
module tb_dog_sprite_render;
  localparam logic [5:0] W = 6'h3F, BG = 6'h01, K = 6'h00;
  localparam logic [5:0] P1 = 6'b100100, P4 = 6'b001100;
  typedef struct {
    int due;
    logic [5:0] rgb;
    logic ins, hs, vs;
    string nm;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q[$];
  logic [5:0] fl_exp [8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dog_sprite_render_if bus();
  dog_sprite_render dut (.clk(clk), .rst(rst), .bus(bus));

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.due != cyc || {bus.r, bus.g, bus.b} != e.rgb || bus.in_sprite != e.ins ||
          bus.hsync_out != e.hs || bus.vsync_out != e.vs) begin
        n_fail++;
        $display("FAIL %s: got rgb=%b in=%b hs=%b vs=%b cyc=%0d, want rgb=%b in=%b hs=%b vs=%b cyc=%0d",
                 e.nm, {bus.r, bus.g, bus.b}, bus.in_sprite, bus.hsync_out, bus.vsync_out, cyc,
                 e.rgb, e.ins, e.hs, e.vs, e.due);
      end
    end
  end

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic d, input logic hs,
                     input logic vs, input logic [5:0] er, input logic ei, input string nm,
                     input logic tk = 1'b0);
    @(negedge clk);
    bus.hpos = h; bus.vpos = v; bus.de = d; bus.hsync_in = hs; bus.vsync_in = vs;
    bus.frame_tick = tk;
    q.push_back('{due: cyc + 2, rgb: er, ins: ei, hs: hs, vs: vs, nm: nm});
  endtask

  task automatic tick(input logic [9:0] px, input logic [8:0] py, input logic [2:0] c,
                      input logic [7:0] h, input logic [1:0] p);
    @(negedge clk);
    bus.posx = px; bus.posy = py; bus.color_idx = c; bus.hits = h; bus.power_state = p;
    bus.de = 1'b0; bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic now(input string nm, input logic [5:0] er, input logic ei, input logic hs,
                     input logic vs);
    n_chk++;
    if ({bus.r, bus.g, bus.b} != er || bus.in_sprite != ei || bus.hsync_out != hs ||
        bus.vsync_out != vs) begin
      n_fail++;
      $display("FAIL %s: got rgb=%b in=%b hs=%b vs=%b, want rgb=%b in=%b hs=%b vs=%b", nm,
               {bus.r, bus.g, bus.b}, bus.in_sprite, bus.hsync_out, bus.vsync_out, er, ei, hs, vs);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d results never appeared, want 0 pending", q.size());
      q.delete();
    end
  endtask

  initial begin
    fl_exp = '{P1, P1, W, W, P1, P1, W, P1};
    bus.frame_tick = 0; bus.hpos = 0; bus.vpos = 0; bus.de = 0; bus.hsync_in = 0;
    bus.vsync_in = 0; bus.posx = 0; bus.posy = 0; bus.color_idx = 0; bus.hits = 0;
    bus.power_state = 0;
    repeat (3) @(negedge clk);
    now("reset_out", K, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    tick(100, 100, 1, 0, 0);
    pix(100, 100, 1, 1, 1, W, 1, "edge_topleft");
    pix(120, 115, 1, 1, 1, P1, 1, "interior_p1");
    pix(99, 115, 1, 1, 1, BG, 0, "left_of_box");
    pix(120, 115, 0, 1, 1, K, 0, "de_low");
    bus.posx = 200;
    pix(120, 115, 1, 1, 1, P1, 1, "no_tick_posx");
    tick(200, 100, 1, 0, 0);
    pix(120, 115, 1, 1, 1, BG, 0, "moved_old_spot");
    pix(220, 115, 1, 1, 1, P1, 1, "moved_new_spot");
    tick(200, 100, 1, 1, 0);
    pix(220, 115, 1, 1, 1, W, 1, "flash_start");
    for (int i = 0; i < 8; i++) begin
      tick(200, 100, 1, 1, 0);
      pix(220, 115, 1, 1, 1, fl_exp[i], 1, $sformatf("flash_decay%0d", i));
    end
    for (int i = 0; i < 9; i++) tick(200, 100, 1, 255, 0);
    tick(200, 100, 1, 0, 0);
    pix(220, 115, 1, 1, 1, P1, 1, "wrap_flash_off_phase");
    tick(200, 100, 1, 0, 0);
    pix(220, 115, 1, 1, 1, W, 1, "wrap_flash_on_phase");
    for (int i = 0; i < 8; i++) tick(200, 100, 1, 0, 0);
    tick(200, 100, 4, 0, 2);
    pix(220, 115, 1, 1, 1, 6'b110011, 1, "pwr_inverted");
    tick(200, 100, 4, 0, 1);
    pix(220, 115, 1, 1, 1, 6'b011101, 1, "pwr_bright");
    tick(200, 100, 4, 0, 3);
    pix(220, 115, 1, 1, 1, P4, 1, "pwr_blink_show");
    tick(200, 100, 4, 0, 3);
    tick(200, 100, 4, 0, 3);
    tick(200, 100, 4, 0, 3);
    pix(220, 115, 1, 1, 1, BG, 1, "pwr_blink_hide");
    tick(592, 448, 1, 0, 0);
    pix(639, 479, 1, 0, 1, W, 1, "corner_639_479");
    pix(640, 479, 0, 1, 0, K, 0, "past_right_de0");
    pix(600, 460, 1, 0, 0, P1, 1, "corner_box_inner");
    bus.posx = 0; bus.posy = 0;
    pix(600, 460, 1, 1, 1, P1, 1, "tick_same_pixel", 1'b1);
    pix(600, 460, 1, 0, 1, BG, 0, "after_tick_pixel");
    drain();
    @(negedge clk);
    rst = 1'b1; bus.hsync_in = 0; bus.vsync_in = 0; bus.de = 1;
    @(negedge clk);
    now("mid_frame_reset", K, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    pix(0, 0, 1, 1, 1, W, 1, "box00_edge");
    pix(10, 10, 1, 1, 1, K, 1, "box00_black");
    pix(47, 31, 1, 1, 0, W, 1, "box00_far_corner");
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
